apb_slave_bank: RTL and testbench

APB completer model with four register-file slaves, sitting directly downstream of the AHB-to-APB bridge. Consumes the bridge's APB outputs (Pselx, Penable, Pwrite, Paddr, Pwdata), performs register reads and writes, and returns Prdata to the bridge. Enforces APB setup/access sequencing and flags protocol violations so bridge misbehaviour is visible at the APB boundary.

---
 rtl/apb_slave_bank.sv | 226 ++++++++++++++++++++++
 tb/tb_apb_slave_bank.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/apb_slave_bank.sv
// apb_slave_bank: APB completer with four register-file slaves placed behind
// the AHB-to-APB bridge. It tracks each transfer through setup and access,
// performs register reads and writes, and flags bus protocol violations.
//
// Configuration macro: APB_SLV_ERRCNT_EN
//   defined   -> err_cnt is a saturating 8-bit violation counter
//   undefined -> err_cnt is tied to 8'h00 and no counter flops are built
//
// The FSM follows the bus one cycle behind. A transfer's setup cycle is
// sampled on the edge into P_SETUP, and its access cycle on the edge into
// P_ACCESS. Read data is therefore loaded on the SETUP->ACCESS edge and
// shown for the whole P_ACCESS cycle. A write commits on the edge leaving
// P_ACCESS, which is before any back-to-back setup can be followed by a
// read of the same register.

module apb_slave_bank #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_LSB = 2
) (
  input  logic        clk,
  input  logic        Hresetn,
  input  logic [3:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Perr,
  output logic [7:0]  err_cnt
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    P_IDLE   = 2'd0,
    P_SETUP  = 2'd1,
    P_ACCESS = 2'd2
  } state_t;

  // True when exactly one select line is asserted.
  function automatic logic is_onehot4(input logic [3:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return (cnt == 3'd1);
  endfunction

  // Encode a one-hot slave select into a slave number.
  function automatic logic [1:0] sel_index(input logic [3:0] v);
    logic [1:0] r;
    case (v)
      4'b0001: r = 2'd0;
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        sel_q;
  logic [IDX_W-1:0]  idx_q;
  logic              write_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       prdata_q, prdata_d;
  logic              perr_q;
  logic [31:0]       regs_q [0:3][0:NUM_REGS-1];

  logic              onehot_s;
  logic              bus_idle_s;
  logic              start_s;
  logic              match_s;
  logic              viol_s;
  logic              capture_s;
  logic              load_rd_s;
  logic              wcap_s;
  logic              commit_s;
  logic [IDX_W-1:0]  idx_s;

  assign idx_s      = Paddr[ADDR_LSB +: IDX_W];
  assign onehot_s   = is_onehot4(Pselx);
  assign bus_idle_s = (Pselx == 4'b0000);
  assign start_s    = onehot_s && !Penable;
  assign match_s    = Penable && (Pselx == sel_q) && (Paddr == addr_q) &&
                      (Pwrite == write_q);

  // State register; an aborted transfer simply returns to idle on reset.
  always_ff @(posedge clk) begin
    if (!Hresetn) begin
      state_q <= P_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode for the setup/access sequence.
  always_comb begin
    state_d = P_IDLE;
    case (state_q)
      P_IDLE: begin
        if (start_s) state_d = P_SETUP;
        else         state_d = P_IDLE;
      end
      P_SETUP: begin
        if (match_s) state_d = P_ACCESS;
        else         state_d = P_IDLE;
      end
      P_ACCESS: begin
        if (start_s) state_d = P_SETUP;
        else         state_d = P_IDLE;
      end
      default: state_d = P_IDLE;
    endcase
  end

  // Per-state strobes: violation, capture, read load, write capture/commit.
  always_comb begin
    viol_s    = 1'b0;
    capture_s = 1'b0;
    load_rd_s = 1'b0;
    wcap_s    = 1'b0;
    commit_s  = 1'b0;
    case (state_q)
      P_IDLE: begin
        capture_s = start_s;
        viol_s    = !start_s && !bus_idle_s;
      end
      P_SETUP: begin
        viol_s    = !match_s;
        load_rd_s = match_s && !write_q;
        wcap_s    = match_s && write_q;
      end
      P_ACCESS: begin
        commit_s  = write_q;
        capture_s = start_s;
        viol_s    = !start_s && !bus_idle_s;
      end
      default: begin
        viol_s = 1'b0;
      end
    endcase
  end

  // Read data is the addressed register on the SETUP->ACCESS edge, else zero.
  always_comb begin
    prdata_d = 32'h0000_0000;
    if (load_rd_s) begin
      prdata_d = regs_q[sel_index(sel_q)][idx_q];
    end else begin
      prdata_d = 32'h0000_0000;
    end
  end

  // Transfer capture registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!Hresetn) begin
      sel_q    <= 4'b0000;
      idx_q    <= '0;
      write_q  <= 1'b0;
      addr_q   <= 32'h0000_0000;
      wdata_q  <= 32'h0000_0000;
      prdata_q <= 32'h0000_0000;
      perr_q   <= 1'b0;
    end else begin
      if (capture_s) begin
        sel_q   <= Pselx;
        idx_q   <= idx_s;
        write_q <= Pwrite;
        addr_q  <= Paddr;
      end
      if (wcap_s) begin
        wdata_q <= Pwdata;
      end
      prdata_q <= prdata_d;
      perr_q   <= viol_s;
    end
  end

  // Register file; a write lands on the edge leaving the access phase.
  always_ff @(posedge clk) begin
    if (!Hresetn) begin
      for (int s = 0; s < 4; s++) begin
        for (int r = 0; r < NUM_REGS; r++) begin
          regs_q[s][r] <= 32'h0000_0000;
        end
      end
    end else if (commit_s) begin
      regs_q[sel_index(sel_q)][idx_q] <= wdata_q;
    end
  end

  assign Prdata = prdata_q;
  assign Perr   = perr_q;

`ifdef APB_SLV_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating violation count; holds at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (viol_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Violation counter register.
  always_ff @(posedge clk) begin
    if (!Hresetn) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_apb_slave_bank.sv
// Testbench for apb_slave_bank: a table of per-cycle bus vectors with
// expected registered outputs, then a hand-written run of 300 violations
// to exercise counter saturation.

module tb_apb_slave_bank;

  logic        clk;
  logic        Hresetn;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Perr;
  logic [7:0]  err_cnt;

  int checks;
  int failures;

  typedef struct {
    logic        rst_n;
    logic [3:0]  sel;
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_prdata;
    logic        exp_perr;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[$];

  apb_slave_bank #(.NUM_REGS(16), .ADDR_LSB(2)) dut (
    .clk(clk), .Hresetn(Hresetn), .Pselx(Pselx), .Penable(Penable),
    .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Prdata(Prdata), .Perr(Perr), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] s, input logic e,
                              input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] ep, input logic ee, input int ec);
    vec_t v;
    v.rst_n = r; v.sel = s; v.en = e; v.wr = w; v.addr = a; v.wdata = d;
    v.exp_prdata = ep; v.exp_perr = ee; v.exp_cnt = ec;
    return v;
  endfunction

  // Expected err_cnt for a given number of violations since reset.
  function automatic logic [7:0] cnt_exp(input int c);
`ifdef APB_SLV_ERRCNT_EN
    return (c > 255) ? 8'd255 : c[7:0];
`else
    return (c >= 0) ? 8'd0 : 8'd0;
`endif
  endfunction

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] s, input logic e,
                       input logic w, input logic [31:0] a, input logic [31:0] d);
    Hresetn = r; Pselx = s; Penable = e; Pwrite = w; Paddr = a; Pwdata = d;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);

    // reset and idle
    vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    // write DEADBEEF to slave 0 reg 3, read back
    vecs.push_back(mk(1'b1, 4'b0001, 1'b0, 1'b1, 32'h8000_000C, 32'hDEAD_BEEF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b1, 32'h8000_000C, 32'hDEAD_BEEF, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0001, 1'b0, 1'b0, 32'h8000_000C, 32'h0, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b0, 32'h8000_000C, 32'h0, 32'hDEAD_BEEF, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    // back-to-back write then read, slave 2 reg 1
    vecs.push_back(mk(1'b1, 4'b0100, 1'b0, 1'b1, 32'h0000_0004, 32'h1111_1111, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0100, 1'b1, 1'b1, 32'h0000_0004, 32'h1111_1111, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0100, 1'b0, 1'b0, 32'h0000_0004, 32'h1111_1111, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0100, 1'b1, 1'b0, 32'h0000_0004, 32'h1111_1111, 32'h1111_1111, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    // upper address bits ignored: slave 0 reg 3 via 0x0000000C
    vecs.push_back(mk(1'b1, 4'b0001, 1'b0, 1'b0, 32'h0000_000C, 32'h0, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b0, 32'h0000_000C, 32'h0, 32'hDEAD_BEEF, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    // slave 1 reg 3 untouched
    vecs.push_back(mk(1'b1, 4'b0010, 1'b0, 1'b0, 32'h0000_000C, 32'h0, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0010, 1'b1, 1'b0, 32'h0000_000C, 32'h0, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    // multi-bit select
    vecs.push_back(mk(1'b1, 4'b0011, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1));
    // Penable high in idle
    vecs.push_back(mk(1'b1, 4'b0100, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 2));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 2));
    // Paddr changes between setup and access: write dropped
    vecs.push_back(mk(1'b1, 4'b0001, 1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_0000, 32'h0, 1'b0, 2));
    vecs.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b1, 32'h0000_0014, 32'hCAFE_0000, 32'h0, 1'b1, 3));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 3));
    vecs.push_back(mk(1'b1, 4'b0001, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 3));
    vecs.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 3));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 3));
    // setup not followed by access
    vecs.push_back(mk(1'b1, 4'b0001, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 3));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 4));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4));
    // reset during access of a write to slave 3 reg 2
    vecs.push_back(mk(1'b1, 4'b1000, 1'b0, 1'b1, 32'h0000_0008, 32'h5A5A_5A5A, 32'h0, 1'b0, 4));
    vecs.push_back(mk(1'b1, 4'b1000, 1'b1, 1'b1, 32'h0000_0008, 32'h5A5A_5A5A, 32'h0, 1'b0, 4));
    vecs.push_back(mk(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h5A5A_5A5A, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b1000, 1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b1000, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    // reset cleared slave 0 reg 3
    vecs.push_back(mk(1'b1, 4'b0001, 1'b0, 1'b0, 32'h0000_000C, 32'h0, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b0, 32'h0000_000C, 32'h0, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    // violation together with reset: reset wins
    vecs.push_back(mk(1'b0, 4'b0011, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 0));
    // Penable held past the access phase
    vecs.push_back(mk(1'b1, 4'b0001, 1'b0, 1'b1, 32'h0, 32'h0000_0001, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b1, 32'h0, 32'h0000_0001, 32'h0, 1'b0, 0));
    vecs.push_back(mk(1'b1, 4'b0001, 1'b1, 1'b1, 32'h0, 32'h0000_0001, 32'h0, 1'b1, 1));
    vecs.push_back(mk(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].sel, vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      @(posedge clk);
      #1;
      check32($sformatf("prdata[v%0d]", i), Prdata, vecs[i].exp_prdata);
      check32($sformatf("perr[v%0d]", i), {31'd0, Perr}, {31'd0, vecs[i].exp_perr});
      check32($sformatf("err_cnt[v%0d]", i), {24'd0, err_cnt}, {24'd0, cnt_exp(vecs[i].exp_cnt)});
    end

    // 300 consecutive violations: counter saturates, Perr pulses each cycle
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check32("sat_reset_cnt", {24'd0, err_cnt}, 32'd0);
    for (int k = 1; k <= 300; k++) begin
      drive(1'b1, 4'b0011, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      check32($sformatf("sat_perr[%0d]", k), {31'd0, Perr}, 32'd1);
      check32($sformatf("sat_cnt[%0d]", k), {24'd0, err_cnt}, {24'd0, cnt_exp(k)});
    end
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check32("sat_perr_idle", {31'd0, Perr}, 32'd0);
    check32("sat_cnt_hold", {24'd0, err_cnt}, {24'd0, cnt_exp(300)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
